branch_pred_ctrl: RTL and testbench

- Dynamic branch-prediction controller for the 5-stage pipeline.
- Keeps a table of 2-bit saturating counters indexed by PC. Gives a taken/not-taken prediction for the branch in ID.
- Resolves the prediction against the real outcome in EX. On a mispredict it drives flush and PC-redirect selection.
- Sits beside the main decoder: consumes its Branch output in ID, and drives the IF/ID and ID/EX flush (nop) inputs.

---
 rtl/bp_pkg.sv | 21 ++
 rtl/bp_sat_ctr.sv | 26 ++
 rtl/branch_pred_ctrl.sv | 93 +++++++++
 tb/tb_branch_pred_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Purpose : shared constants for the branch-prediction controller.
// Latency : n/a (package only).
// Backpressure : n/a.
package bp_pkg;

  // 2-bit saturating counter states; bit 1 is the taken prediction.
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // PC source select driven towards the fetch mux.
  localparam logic [1:0] RD_SEQ    = 2'b00;  // pc+4
  localparam logic [1:0] RD_PRED   = 2'b01;  // ID predicted target
  localparam logic [1:0] RD_EX_TGT = 2'b10;  // EX branch target
  localparam logic [1:0] RD_EX_SEQ = 2'b11;  // EX pc+4

  // Default log2 of the pattern-history table depth.
  localparam int IDX_W_DEF = 4;

endpackage

// File: rtl/bp_sat_ctr.sv
// Purpose : next-state function of one 2-bit saturating branch counter.
// Latency : purely combinational, zero cycles.
// Backpressure : none; en=0 simply holds the state.
// Ports   : state (current counter), taken (resolved outcome),
//           en (apply update), next (counter value after update).
module bp_sat_ctr
  import bp_pkg::*;
(
  input  logic [1:0] state,
  input  logic       taken,
  input  logic       en,
  output logic [1:0] next
);

  always_comb begin
    next = state;
    if (en) begin
      if (taken) begin
        if (state != ST) next = state + 2'd1;
      end else begin
        if (state != SNT) next = state - 2'd1;
      end
    end
  end

endmodule

// File: rtl/branch_pred_ctrl.sv
// Purpose : dynamic branch predictor (16x2-bit PHT) with EX resolution, flush and redirect select.
// Latency : prediction, flush and redirect are combinational; table/stat updates land on the next edge.
// Backpressure : stall_i only masks the ID redirect; EX updates and statistics ignore it.
// Ports   : clk_i/rst_i; ID side id_branch_i, id_pc_i, stall_i -> predict_taken_o;
//           EX side ex_branch_i, ex_pc_i, ex_taken_i, ex_pred_i -> flush_o, redirect_sel_o;
//           branch_cnt_o / mispred_cnt_o saturating statistics.
module branch_pred_ctrl
  import bp_pkg::*;
#(
  parameter int         IDX_W      = IDX_W_DEF,
  parameter logic [1:0] INIT_STATE = WT,
  parameter int         CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_branch_i,
  input  logic [31:0]      id_pc_i,
  input  logic             stall_i,
  output logic             predict_taken_o,
  input  logic             ex_branch_i,
  input  logic [31:0]      ex_pc_i,
  input  logic             ex_taken_i,
  input  logic             ex_pred_i,
  output logic             flush_o,
  output logic [1:0]       redirect_sel_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam int NENT = 1 << IDX_W;

  logic [1:0]       pht_q [NENT];
  logic [IDX_W-1:0] id_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [1:0]       ex_cur;
  logic [1:0]       ex_next;
  logic             mispred;

  // Word-aligned PCs: bits [1:0] are dropped, upper bits alias by design.
  assign id_idx = id_pc_i[IDX_W+1:2];
  assign ex_idx = ex_pc_i[IDX_W+1:2];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{id_pc_i[31:IDX_W+2], id_pc_i[1:0],
                            ex_pc_i[31:IDX_W+2], ex_pc_i[1:0]};

  // Read of the registered table: a same-cycle EX write is not bypassed.
  assign predict_taken_o = id_branch_i & pht_q[id_idx][1];

  assign mispred = ex_branch_i & (ex_taken_i ^ ex_pred_i);
  assign ex_cur  = pht_q[ex_idx];

  bp_sat_ctr u_sat_ctr (
    .state (ex_cur),
    .taken (ex_taken_i),
    .en    (ex_branch_i),
    .next  (ex_next)
  );

  // EX mispredict outranks any ID redirect, stalled or not; nothing
  // redirects while reset is held.
  always_comb begin
    flush_o        = 1'b0;
    redirect_sel_o = RD_SEQ;
    if (!rst_i) begin
      if (mispred) begin
        flush_o        = 1'b1;
        redirect_sel_o = ex_taken_i ? RD_EX_TGT : RD_EX_SEQ;
      end else if (predict_taken_o && !stall_i) begin
        redirect_sel_o = RD_PRED;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NENT; i++) pht_q[i] <= INIT_STATE;
    end else if (ex_branch_i) begin
      pht_q[ex_idx] <= ex_next;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      branch_cnt_o  <= '0;
      mispred_cnt_o <= '0;
    end else begin
      if (ex_branch_i && (branch_cnt_o != '1)) branch_cnt_o <= branch_cnt_o + 1'b1;
      if (mispred && (mispred_cnt_o != '1))    mispred_cnt_o <= mispred_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Purpose : self-checking bench for branch_pred_ctrl (vector table + scoreboard queue).
// Latency : outputs sampled on the falling edge of each driven cycle.
// Backpressure : n/a.
module tb_branch_pred_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_branch = 1'b0;
  logic [31:0] id_pc = '0;
  logic        stall = 1'b0;
  logic        ex_branch = 1'b0;
  logic [31:0] ex_pc = '0;
  logic        ex_taken = 1'b0;
  logic        ex_pred = 1'b0;

  logic        predict_taken, flush;
  logic [1:0]  redirect_sel;
  logic [15:0] branch_cnt, mispred_cnt;

  logic        s_predict_taken, s_flush;
  logic [1:0]  s_redirect_sel;
  logic [3:0]  s_branch_cnt, s_mispred_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  branch_pred_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .id_branch_i(id_branch), .id_pc_i(id_pc), .stall_i(stall),
    .predict_taken_o(predict_taken),
    .ex_branch_i(ex_branch), .ex_pc_i(ex_pc), .ex_taken_i(ex_taken), .ex_pred_i(ex_pred),
    .flush_o(flush), .redirect_sel_o(redirect_sel),
    .branch_cnt_o(branch_cnt), .mispred_cnt_o(mispred_cnt)
  );

  // Narrow-counter instance so statistics saturation is reachable quickly.
  branch_pred_ctrl #(.CNT_W(4)) dut_sat (
    .clk_i(clk), .rst_i(rst),
    .id_branch_i(id_branch), .id_pc_i(id_pc), .stall_i(stall),
    .predict_taken_o(s_predict_taken),
    .ex_branch_i(ex_branch), .ex_pc_i(ex_pc), .ex_taken_i(ex_taken), .ex_pred_i(ex_pred),
    .flush_o(s_flush), .redirect_sel_o(s_redirect_sel),
    .branch_cnt_o(s_branch_cnt), .mispred_cnt_o(s_mispred_cnt)
  );

  typedef struct {
    logic        id_branch;
    logic [31:0] id_pc;
    logic        stall;
    logic        ex_branch;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic        ex_pred;
    logic        exp_pred;
    logic        exp_flush;
    logic [1:0]  exp_sel;
    int          exp_b;   // counts visible during this cycle
    int          exp_m;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];
  vec_t sb_q [$];

  function automatic vec_t mk(logic ib, logic [31:0] ipc, logic st,
                              logic eb, logic [31:0] epc, logic et, logic ep,
                              logic xp, logic xf, logic [1:0] xs, int xb, int xm);
    vec_t v;
    v.id_branch = ib; v.id_pc = ipc; v.stall = st;
    v.ex_branch = eb; v.ex_pc = epc; v.ex_taken = et; v.ex_pred = ep;
    v.exp_pred = xp; v.exp_flush = xf; v.exp_sel = xs; v.exp_b = xb; v.exp_m = xm;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    id_branch = 1'b0; id_pc = '0; stall = 1'b0;
    ex_branch = 1'b0; ex_pc = '0; ex_taken = 1'b0; ex_pred = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t e;

    // Table entries: entry = pc[5:2]; all start at weakly taken (10).
    //             ib  id_pc        st  eb  ex_pc        et  ep   xp  xf  sel    b  m
    // Saturate entry 4 down: 10 -> 01 -> 00 -> 00.
    vecs[0]  = mk(1, 32'h10, 0,  1, 32'h10, 0, 1,  1, 1, 2'b11, 0, 0);
    vecs[1]  = mk(1, 32'h10, 0,  1, 32'h10, 0, 1,  0, 1, 2'b11, 1, 1);
    vecs[2]  = mk(1, 32'h10, 0,  1, 32'h10, 0, 0,  0, 0, 2'b00, 2, 2);
    vecs[3]  = mk(1, 32'h10, 0,  0, 32'h0,  0, 0,  0, 0, 2'b00, 3, 2);
    // Mispredict taken on entry 8 (10 -> 11).
    vecs[4]  = mk(0, 32'h20, 0,  1, 32'h20, 1, 0,  0, 1, 2'b10, 3, 2);
    vecs[5]  = mk(1, 32'h20, 0,  0, 32'h0,  0, 0,  1, 0, 2'b01, 4, 3);
    // Priority: EX not-taken mispredict + stalled ID taken prediction; entry 12 -> 01.
    vecs[6]  = mk(1, 32'h20, 1,  1, 32'h30, 0, 1,  1, 1, 2'b11, 4, 3);
    // Same-index collision on entry 0: old value read, new value next cycle.
    vecs[7]  = mk(1, 32'h40, 0,  1, 32'h40, 0, 1,  1, 1, 2'b11, 5, 4);
    vecs[8]  = mk(1, 32'h40, 0,  0, 32'h0,  0, 0,  0, 0, 2'b00, 6, 5);
    // Alias: update via pc 0x04, observe via pc 0x44 (both entry 1).
    vecs[9]  = mk(0, 32'h0,  0,  1, 32'h04, 0, 0,  0, 0, 2'b00, 6, 5);
    vecs[10] = mk(1, 32'h44, 0,  0, 32'h0,  0, 0,  0, 0, 2'b00, 7, 5);
    // Stall masks ID redirect, prediction re-issued when it clears.
    vecs[11] = mk(1, 32'h24, 1,  0, 32'h0,  0, 0,  1, 0, 2'b00, 7, 5);
    vecs[12] = mk(1, 32'h24, 0,  0, 32'h0,  0, 0,  1, 0, 2'b01, 7, 5);
    // ex_branch=0 with disagreeing outcome: no flush, no update, no count.
    vecs[13] = mk(0, 32'h20, 0,  0, 32'h20, 1, 0,  0, 0, 2'b00, 7, 5);
    vecs[14] = mk(1, 32'h20, 0,  0, 32'h0,  0, 0,  1, 0, 2'b01, 7, 5);
    // Entry 12 was updated while stalled -> now 01.
    vecs[15] = mk(1, 32'h30, 0,  0, 32'h0,  0, 0,  0, 0, 2'b00, 7, 5);
    // Upper-bit alias of entry 4 sees the saturated 00.
    vecs[16] = mk(1, 32'hFFF0_0010, 0, 0, 32'h0, 0, 0, 0, 0, 2'b00, 7, 5);

    // ---------------- reset state ----------------
    drive_idle();
    ex_branch = 1'b1; ex_taken = 1'b1; ex_pred = 1'b0;  // would mispredict if live
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      id_branch = 1'b1;
      id_pc = (32'(i) << 2) | (32'(i) << 12);
      #1;
      chk($sformatf("rst_pred_%0d", i), int'(predict_taken), 1);
    end
    chk("rst_flush", int'(flush), 0);
    chk("rst_sel", int'(redirect_sel), 0);
    chk("rst_bcnt", int'(branch_cnt), 0);
    chk("rst_mcnt", int'(mispred_cnt), 0);
    @(posedge clk);
    #1;
    drive_idle();
    rst = 1'b0;

    // ---------------- vector table with scoreboard ----------------
    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      id_branch = vecs[i].id_branch; id_pc = vecs[i].id_pc; stall = vecs[i].stall;
      ex_branch = vecs[i].ex_branch; ex_pc = vecs[i].ex_pc;
      ex_taken  = vecs[i].ex_taken;  ex_pred = vecs[i].ex_pred;
      sb_q.push_back(vecs[i]);
      @(negedge clk);
      if (sb_q.size() == 0) begin
        chk($sformatf("v%0d_sb_empty", i), 0, 1);
      end else begin
        e = sb_q.pop_front();
        chk($sformatf("v%0d_pred", i),  int'(predict_taken), int'(e.exp_pred));
        chk($sformatf("v%0d_flush", i), int'(flush),         int'(e.exp_flush));
        chk($sformatf("v%0d_sel", i),   int'(redirect_sel),  int'(e.exp_sel));
        chk($sformatf("v%0d_bcnt", i),  int'(branch_cnt),    e.exp_b);
        chk($sformatf("v%0d_mcnt", i),  int'(mispred_cnt),   e.exp_m);
      end
    end

    // ---------------- mid-operation asynchronous reset ----------------
    @(posedge clk);
    #1;
    drive_idle();
    id_branch = 1'b1; id_pc = 32'h10;   // entry 4 is saturated not-taken
    #1;
    chk("mid_pre_pred", int'(predict_taken), 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_pred", int'(predict_taken), 1);
    chk("mid_rst_bcnt", int'(branch_cnt), 0);
    chk("mid_rst_mcnt", int'(mispred_cnt), 0);
    chk("mid_rst_sel", int'(redirect_sel), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_idle();

    // ---------------- statistics saturation ----------------
    ex_branch = 1'b1; ex_pc = 32'h0; ex_taken = 1'b1; ex_pred = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    ex_branch = 1'b0;
    chk("cnt_b_20", int'(branch_cnt), 20);
    chk("cnt_m_20", int'(mispred_cnt), 20);
    chk("sat_b", int'(s_branch_cnt), 15);
    chk("sat_m", int'(s_mispred_cnt), 15);
    @(posedge clk);
    #1;
    chk("sat_b_hold", int'(s_branch_cnt), 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
